sync_down_counter: RTL and testbench
====================================

Name: sync_down_counter

Overview:
- Synchronous down counter that complements the team's synchronous up counter (clk/rst/count style): counts toward zero instead of up.
- Adds parallel load, count enable, a reload register and three terminal-count modes: wrap, auto-reload and one-shot.
- Serves as a timer/divider primitive; tc is used as a strobe by downstream logic.
- Single clock domain.

Parameters:
- WIDTH, 4, counter and load-value width in bits.
- RST_VAL, 2**WIDTH-1, value loaded into count and reload_reg on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- en  input  1  count enable; decrement on an edge when high.
- load  input  1  synchronous parallel load; has priority over en.
- load_val  input  WIDTH  value captured into count and reload_reg on load.
- mode  input  2  action at zero: 00 wrap, 01 auto-reload, 10 one-shot, 11 treated as 00.
- count  output  WIDTH  current count value, registered.
- zero  output  1  combinational, (count == 0).
- tc  output  1  combinational terminal-count strobe.
- done  output  1  registered, sticky one-shot-expired flag.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, mid-cycle included):
  - count = RST_VAL, reload_reg = RST_VAL.
  - state = RUN, done = 0.
  - zero and tc follow count, so zero = 0 and tc = 0 when RST_VAL != 0.
- Internal state machine, 2 states:
  - RUN: normal counting.
  - HALT: one-shot expired; count frozen at 0; en ignored.
- Per rising edge, priority order:
  1. load=1: count <= load_val; reload_reg <= load_val; state <= RUN; done <= 0. Applies in either state and any mode.
  2. state=HALT: hold everything.
  3. en=1 and count != 0: count <= count-1.
  4. en=1 and count == 0, action by mode:
     - 00 or 11: count <= all ones (2**WIDTH-1).
     - 01: count <= reload_reg.
     - 10: count stays 0; state <= HALT; done <= 1.
  5. en=0: hold.
- tc = en & ~load & zero & (state==RUN).
  - Asserted in the cycle whose closing edge performs the wrap, reload or halt.
  - Wrap mode with en held high: exactly one cycle of tc per 2**WIDTH cycles.
- Latency:
  - load_val appears on count one edge after load.
  - Decrement is visible one edge after en.
- Mode changes take effect at the next zero event. Changing mode while in HALT does not leave HALT; only load or reset does.
- load_val = 0:
  - Mode 01: count stays 0 and tc is high every enabled cycle (divide-by-1).
  - Mode 10: tc pulses once, then the block enters HALT.
- Arithmetic is unsigned modulo 2**WIDTH. No signed behaviour; no underflow flag beyond tc.
- No X propagation: all registers have reset values.

Decomposition:
- Package sync_counter_pkg holds:
  - Mode constants MODE_WRAP=2'b00, MODE_RELOAD=2'b01, MODE_ONESHOT=2'b10.
  - State encoding ST_RUN=1'b0, ST_HALT=1'b1.
- No sub-module: next-count selection and the 2-state FSM sit in one always block plus combinational assigns.
- The existing up counter stays separate.

Test Plan:
- Clock period 10 ns.
- Reset release at 12 ns, en=1, mode=00 -> count 15,14,...,1,0,15,14; tc high only in the single cycle where count=0; zero matches.
- mode=01, load=1 with load_val=5 for one cycle, then en=1 -> count 5,4,3,2,1,0,5,4...; tc pulses every 6 cycles; done stays 0.
- mode=10, load 3, en=1 -> 3,2,1,0, then held at 0; one tc pulse; done=1 from the edge after count=0 onward. Then load 7 -> count=7, done=0, counting resumes.
- load=1 (load_val=9) and en=1 in the same cycle at count=4 -> next count=9, not 3; tc=0 even if count was 0 in that cycle.
- Drive rst=0 at count=9 between edges -> count=15 and done=0 immediately, before the next edge. en=0 for 5 cycles afterward -> count holds 15.
- mode switched from 00 to 10 at count=2 with en=1 -> 1, 0, then HALT with done=1. Switching mode back to 00 while halted -> count stays 0 until load.

Source files
------------

// File: rtl/sync_counter_pkg.sv
// Shared constants for the synchronous counter family: terminal-count modes
// and the down counter's run/halt state encoding.
package sync_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/sync_down_counter.sv
// Down counter with parallel load, count enable, reload register and
// wrap / auto-reload / one-shot behaviour at zero; tc strobes on the zero event.
module sync_down_counter
    import sync_counter_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             done
);

    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    state_t           state_reg, state_next;
    logic             done_reg, done_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg  <= RST_VAL;
            reload_reg <= RST_VAL;
            state_reg  <= ST_RUN;
            done_reg   <= 1'b0;
        end else begin
            count_reg  <= count_next;
            reload_reg <= reload_next;
            state_reg  <= state_next;
            done_reg   <= done_next;
        end
    end

    // Load beats everything, including HALT; HALT then freezes all state.
    always_comb begin
        count_next  = count_reg;
        reload_next = reload_reg;
        state_next  = state_reg;
        done_next   = done_reg;
        if (load) begin
            count_next  = load_val;
            reload_next = load_val;
            state_next  = ST_RUN;
            done_next   = 1'b0;
        end else if (state_reg == ST_HALT) begin
            count_next = count_reg;
        end else if (en) begin
            if (count_reg != '0) begin
                count_next = count_reg - WIDTH'(1);
            end else begin
                case (mode)
                    MODE_RELOAD:  count_next = reload_reg;
                    MODE_ONESHOT: begin
                        state_next = ST_HALT;
                        done_next  = 1'b1;
                    end
                    default:      count_next = '1;
                endcase
            end
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);
    assign tc    = en & ~load & zero & (state_reg == ST_RUN);
    assign done  = done_reg;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed-vector bench: stimulus pushes the hand-computed expected outputs of
// each cycle into a queue; a negedge monitor pops and compares.
module tb_sync_down_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [1:0] mode;
    logic [3:0] count;
    logic       zero;
    logic       tc;
    logic       done;

    typedef struct {
        logic [3:0] c;
        logic       t;
        logic       d;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    sync_down_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .count    (count),
        .zero     (zero),
        .tc       (tc),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".count"}, count, e.c);
            check({e.name, ".zero"}, {3'b0, zero}, {3'b0, (e.c == 4'd0)});
            check({e.name, ".tc"}, {3'b0, tc}, {3'b0, e.t});
            check({e.name, ".done"}, {3'b0, done}, {3'b0, e.d});
            $display("cycle %-10s en=%0b load=%0b lv=%0d mode=%0d count=%0d tc=%0b done=%0b",
                     e.name, en, load, load_val, mode, count, tc, done);
        end
    end

    task automatic push(input string name, input logic [3:0] c, input logic t, input logic d);
        exp_t e;
        e.c = c; e.t = t; e.d = d; e.name = name;
        exp_q.push_back(e);
    endtask

    // Drive one cycle's inputs, record what the DUT must show before the edge.
    task automatic step(input string name, input logic e_en, input logic e_load,
                        input logic [3:0] lv, input logic [1:0] m,
                        input logic [3:0] c, input logic t, input logic d);
        en = e_en; load = e_load; load_val = lv; mode = m;
        push(name, c, t, d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; load = 1'b0; load_val = 4'd0; mode = 2'b00;
        push("reset", 4'd15, 1'b0, 1'b0);
        #12 rst = 1'b1;
        @(posedge clk);
        #1;

        // Wrap: first edge after release already took 15 -> 14.
        for (int i = 0; i < 18; i++) begin
            logic [3:0] c;
            c = 4'(14 - i);
            step("wrap", 1'b1, 1'b0, 4'd0, 2'b00, c, (c == 4'd0), 1'b0);
        end

        // Auto-reload with 5: period of 6 cycles.
        step("rl_load", 1'b0, 1'b1, 4'd5, 2'b01, 4'd12, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            logic [3:0] c;
            c = 4'(5 - (i % 6));
            step("reload", 1'b1, 1'b0, 4'd0, 2'b01, c, (c == 4'd0), 1'b0);
        end

        // One-shot from 3, then reload from HALT with 7.
        step("os_load", 1'b1, 1'b1, 4'd3, 2'b10, 4'd3, 1'b0, 1'b0);
        step("oneshot", 1'b1, 1'b0, 4'd0, 2'b10, 4'd3, 1'b0, 1'b0);
        step("oneshot", 1'b1, 1'b0, 4'd0, 2'b10, 4'd2, 1'b0, 1'b0);
        step("oneshot", 1'b1, 1'b0, 4'd0, 2'b10, 4'd1, 1'b0, 1'b0);
        step("os_zero", 1'b1, 1'b0, 4'd0, 2'b10, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("os_halt", 1'b1, 1'b0, 4'd0, 2'b10, 4'd0, 1'b0, 1'b1);
        step("os_reld", 1'b0, 1'b1, 4'd7, 2'b00, 4'd0, 1'b0, 1'b1);
        step("resume", 1'b1, 1'b0, 4'd0, 2'b00, 4'd7, 1'b0, 1'b0);
        step("resume", 1'b1, 1'b0, 4'd0, 2'b00, 4'd6, 1'b0, 1'b0);
        step("resume", 1'b1, 1'b0, 4'd0, 2'b00, 4'd5, 1'b0, 1'b0);

        // Load beats enable at count 4.
        step("ld_pri", 1'b1, 1'b1, 4'd9, 2'b00, 4'd4, 1'b0, 1'b0);
        step("ld_pri2", 1'b0, 1'b0, 4'd0, 2'b00, 4'd9, 1'b0, 1'b0);

        // Asynchronous reset between edges at count 9.
        #1 rst = 1'b0;
        push("arst", 4'd15, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 5; i++)
            step("hold", 1'b0, 1'b0, 4'd0, 2'b00, 4'd15, 1'b0, 1'b0);

        // Mode switch to one-shot at count 2; mode back to wrap stays halted.
        step("ms_load", 1'b0, 1'b1, 4'd2, 2'b00, 4'd15, 1'b0, 1'b0);
        step("ms_os", 1'b1, 1'b0, 4'd0, 2'b10, 4'd2, 1'b0, 1'b0);
        step("ms_os", 1'b1, 1'b0, 4'd0, 2'b10, 4'd1, 1'b0, 1'b0);
        step("ms_zero", 1'b1, 1'b0, 4'd0, 2'b10, 4'd0, 1'b1, 1'b0);
        step("ms_halt", 1'b1, 1'b0, 4'd0, 2'b10, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("ms_wrap", 1'b1, 1'b0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b1);

        // Divide-by-1: reload mode with load_val 0.
        step("d1_load", 1'b1, 1'b1, 4'd0, 2'b01, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("div1", 1'b1, 1'b0, 4'd0, 2'b01, 4'd0, 1'b1, 1'b0);
        // Load at zero in RUN suppresses tc.
        step("ld_zero", 1'b1, 1'b1, 4'd9, 2'b01, 4'd0, 1'b0, 1'b0);
        step("ld_zero2", 1'b0, 1'b0, 4'd0, 2'b01, 4'd9, 1'b0, 1'b0);

        // One-shot with load_val 0: single tc then HALT.
        step("os0_load", 1'b0, 1'b1, 4'd0, 2'b10, 4'd9, 1'b0, 1'b0);
        step("os0_tc", 1'b1, 1'b0, 4'd0, 2'b10, 4'd0, 1'b1, 1'b0);
        step("os0_halt", 1'b1, 1'b0, 4'd0, 2'b10, 4'd0, 1'b0, 1'b1);
        step("os0_halt", 1'b1, 1'b0, 4'd0, 2'b10, 4'd0, 1'b0, 1'b1);

        // Reset while halted clears done immediately.
        en = 1'b0;
        #1 rst = 1'b0;
        push("arst_done", 4'd15, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        step("post_rst", 1'b0, 1'b0, 4'd0, 2'b00, 4'd15, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
